fpu: RTL and testbench

- Memory-mapped single-precision (IEEE-754 binary32) floating-point coprocessor on an 8-bit peripheral bus.
- The CPU writes operands A and B bytewise, writes an opcode, then strobes start.
- The block runs add, sub, mul or div, raises cmd_end, and the CPU reads the 32-bit result bytewise.

---
 rtl/fpu.sv | 219 +++++++++++++++++++++
 tb/tb_fpu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu.sv
// ============================================================================
// fpu : byte-bus single-precision coprocessor (add/sub/mul/div, truncating)
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] databus_in,
  output logic [7:0] databus_out,
  input  logic [3:0] addr,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic       end_ack,
  output logic       cmd_end,
  output logic       busy
);
  localparam logic [1:0]  c_OP_SUB = 2'd1;
  localparam logic [1:0]  c_OP_MUL = 2'd2;
  localparam logic [1:0]  c_OP_DIV = 2'd3;
  localparam logic [31:0] c_QNAN   = 32'h7FC0_0000;
  localparam logic [30:0] c_INF    = {8'hFF, 23'd0};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_EXEC, S_NORM, S_DONE} state_t;
  state_t r_state, w_next;

  logic        r_wr_q, r_busy, r_cmd_end, r_spec, r_s, r_zs;
  logic [31:0] r_a, r_b, r_res, r_wa, r_wb, r_spec_val, r_norm;
  logic [1:0]  r_op, r_wop;
  logic [49:0] r_m;
  logic signed [10:0] r_e;
  logic [25:0] r_rem, r_q;
  logic [4:0]  r_cnt;

  logic        w_wstb, w_go;
  logic        w_sa, w_sb, w_sx, w_za, w_zb, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic [7:0]  w_ea, w_eb, w_big_e, w_sml_e, w_d;
  logic [23:0] w_ma, w_mb, w_big_m, w_sml_m;
  logic        w_a_ge, w_sticky, w_spec, w_qbit;
  logic [31:0] w_spec_val, w_res;
  logic [49:0] w_big_full, w_sml_full, w_sml_sh, w_sum;
  logic [47:0] w_prod;
  logic [25:0] w_rem_sub, w_rem_nx, w_q_nx;
  logic [5:0]  w_p;
  logic [22:0] w_frac;
  logic signed [10:0] w_bexp;
  logic [1:0]  w_ridx;

  assign w_wstb = ~cs & ~wr & r_wr_q;
  assign w_go   = w_wstb & (addr == 4'd9) & ~r_busy;

  // Operand decode; subtraction is folded into B's effective sign.
  assign w_ea    = r_wa[30:23];
  assign w_eb    = r_wb[30:23];
  assign w_za    = (w_ea == 8'd0);
  assign w_zb    = (w_eb == 8'd0);
  assign w_ma    = w_za ? 24'd0 : {1'b1, r_wa[22:0]};
  assign w_mb    = w_zb ? 24'd0 : {1'b1, r_wb[22:0]};
  assign w_nan_a = (&w_ea) & (|r_wa[22:0]);
  assign w_nan_b = (&w_eb) & (|r_wb[22:0]);
  assign w_inf_a = (&w_ea) & ~(|r_wa[22:0]);
  assign w_inf_b = (&w_eb) & ~(|r_wb[22:0]);
  assign w_sa    = r_wa[31];
  assign w_sb    = r_wb[31] ^ (r_wop == c_OP_SUB);
  assign w_sx    = r_wa[31] ^ r_wb[31];

  always_comb begin
    w_spec     = 1'b1;
    w_spec_val = c_QNAN;
    if (!(w_nan_a | w_nan_b)) begin
      case (r_wop)
        c_OP_MUL: begin
          if ((w_inf_a & w_zb) | (w_za & w_inf_b)) w_spec_val = c_QNAN;
          else if (w_inf_a | w_inf_b)              w_spec_val = {w_sx, c_INF};
          else                                     w_spec     = 1'b0;
        end
        c_OP_DIV: begin
          if ((w_za & w_zb) | (w_inf_a & w_inf_b)) w_spec_val = c_QNAN;
          else if (w_inf_a | w_zb)                 w_spec_val = {w_sx, c_INF};
          else if (w_inf_b)                        w_spec_val = {w_sx, 31'd0};
          else                                     w_spec     = 1'b0;
        end
        default: begin
          if (w_inf_a & w_inf_b & (w_sa != w_sb)) w_spec_val = c_QNAN;
          else if (w_inf_a)                       w_spec_val = {w_sa, c_INF};
          else if (w_inf_b)                       w_spec_val = {w_sb, c_INF};
          else                                    w_spec     = 1'b0;
        end
      endcase
    end
  end

  // Add/sub: bits shifted out of the smaller operand knock one LSB off a
  // subtraction so that truncation of the wide difference stays exact.
  assign w_a_ge     = {w_ea, w_ma} >= {w_eb, w_mb};
  assign w_big_e    = w_a_ge ? w_ea : w_eb;
  assign w_sml_e    = w_a_ge ? w_eb : w_ea;
  assign w_big_m    = w_a_ge ? w_ma : w_mb;
  assign w_sml_m    = w_a_ge ? w_mb : w_ma;
  assign w_d        = w_big_e - w_sml_e;
  assign w_big_full = {2'b00, w_big_m, 24'd0};
  assign w_sml_full = {2'b00, w_sml_m, 24'd0};
  assign w_sml_sh   = (w_d >= 8'd50) ? 50'd0 : (w_sml_full >> w_d);
  assign w_sticky   = (w_d >= 8'd50) ? (|w_sml_m) : ((w_sml_sh << w_d) != w_sml_full);
  assign w_sum      = (w_sa == w_sb) ? (w_big_full + w_sml_sh)
                                     : (w_big_full - w_sml_sh - {49'd0, w_sticky});

  assign w_prod    = w_ma * w_mb;
  assign w_qbit    = r_rem >= {2'b00, w_mb};
  assign w_rem_sub = w_qbit ? (r_rem - {2'b00, w_mb}) : r_rem;
  assign w_rem_nx  = w_rem_sub << 1;
  assign w_q_nx    = (r_q << 1) | {25'd0, w_qbit};

  // r_m is a fixed-point magnitude with value r_m * 2^(r_e - 127 - 47).
  always_comb begin
    w_p = 6'd0;
    for (int i = 0; i < 50; i++) if (r_m[i]) w_p = 6'(i);
  end
  assign w_frac = 23'((r_m << (6'd49 - w_p)) >> 26);
  assign w_bexp = r_e + $signed({5'd0, w_p}) - 11'sd47;

  always_comb begin
    if (r_m == 50'd0)             w_res = {r_zs, 31'd0};
    else if (w_bexp >= 11'sd255)  w_res = {r_s, c_INF};
    else if (w_bexp <= 11'sd0)    w_res = {r_s, 31'd0};
    else                          w_res = {r_s, w_bexp[7:0], w_frac};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_go) w_next = S_UNPACK;
      S_UNPACK: w_next = S_EXEC;
      S_EXEC:   if (r_wop != c_OP_DIV || r_cnt == 5'd25) w_next = S_NORM;
      S_NORM:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_wr_q <= 1'b1;     r_a <= '0;       r_b <= '0;      r_op <= '0;
      r_res <= '0;        r_busy <= 1'b0;  r_cmd_end <= 1'b0;
      r_wa <= '0;         r_wb <= '0;      r_wop <= '0;
      r_spec <= 1'b0;     r_spec_val <= '0; r_norm <= '0;
      r_m <= '0;          r_e <= '0;       r_s <= 1'b0;    r_zs <= 1'b0;
      r_rem <= '0;        r_q <= '0;       r_cnt <= '0;
    end else begin
      r_wr_q <= wr;
      if (w_wstb) begin
        if (addr[3:2] == 2'd0)  r_a[{addr[1:0], 3'b000} +: 8] <= databus_in;
        else if (addr[3:2] == 2'd1) r_b[{addr[1:0], 3'b000} +: 8] <= databus_in;
        else if (addr == 4'd8)  r_op <= databus_in[1:0];
      end
      if (w_go) begin
        r_busy <= 1'b1; r_cmd_end <= 1'b0;
        r_wa <= r_a; r_wb <= r_b; r_wop <= r_op;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0; r_cmd_end <= 1'b1;
        r_res  <= r_spec ? r_spec_val : r_norm;
      end else if (end_ack) begin
        r_cmd_end <= 1'b0;
      end
      case (r_state)
        S_UNPACK: begin
          r_spec <= w_spec; r_spec_val <= w_spec_val;
          r_rem <= {2'b00, w_ma}; r_q <= '0; r_cnt <= '0;
        end
        S_EXEC: begin
          if (r_wop == c_OP_MUL) begin
            r_m <= {1'b0, w_prod, 1'b0};
            r_e <= $signed({3'd0, w_ea}) + $signed({3'd0, w_eb}) - 11'sd127;
            r_s <= w_sx; r_zs <= w_sx;
          end else if (r_wop == c_OP_DIV) begin
            r_rem <= w_rem_nx; r_q <= w_q_nx; r_cnt <= r_cnt + 5'd1;
            r_m <= {2'b00, w_q_nx, 22'd0};
            r_e <= $signed({3'd0, w_ea}) - $signed({3'd0, w_eb}) + 11'sd127;
            r_s <= w_sx; r_zs <= w_sx;
          end else begin
            r_m <= w_sum; r_e <= $signed({3'd0, w_big_e});
            r_s <= w_a_ge ? w_sa : w_sb; r_zs <= w_sa & w_sb;
          end
        end
        S_NORM:  r_norm <= w_res;
        default: ;
      endcase
    end
  end

  assign w_ridx = addr[1:0] - 2'd1;

  always_comb begin
    databus_out = 8'h00;
    if (!cs && !rd) begin
      case (addr)
        4'd0, 4'd1, 4'd2, 4'd3:   databus_out = r_a[{addr[1:0], 3'b000} +: 8];
        4'd4, 4'd5, 4'd6, 4'd7:   databus_out = r_b[{addr[1:0], 3'b000} +: 8];
        4'd8:                     databus_out = {6'd0, r_op};
        4'd9, 4'd10, 4'd11, 4'd12: databus_out = r_res[{w_ridx, 3'b000} +: 8];
        4'd13:                    databus_out = {6'd0, r_cmd_end, r_busy};
        default:                  databus_out = 8'h00;
      endcase
    end
  end

  assign cmd_end = r_cmd_end;
  assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fpu.sv
// ============================================================================
// tb_fpu : vector table, real-arithmetic reference model and bus sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fpu;
  logic       clk = 1'b0, arst = 1'b0;
  logic [7:0] databus_in = '0, databus_out;
  logic [3:0] addr = '0;
  logic       cs = 1'b1, rd = 1'b1, wr = 1'b1, end_ack = 1'b0;
  logic       cmd_end, busy;
  int         n_err = 0, n_chk = 0;

  fpu dut (
    .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out),
    .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack),
    .cmd_end(cmd_end), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [31:0] exp;
    int          maxlat;
  } vec_t;
  vec_t vt[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs = 1'b0; rd = 1'b0;
    #1 d = databus_out;
    cs = 1'b1; rd = 1'b1;
  endtask

  task automatic read32(input logic [3:0] base, output logic [31:0] v);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      bus_read(base + 4'(i), b);
      v[8*i +: 8] = b;
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    for (int i = 0; i < 4; i++) bus_write(4'(i), a[8*i +: 8]);
    for (int i = 0; i < 4; i++) bus_write(4'(4 + i), b[8*i +: 8]);
    bus_write(4'd8, {6'd0, op});
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!cmd_end && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start_and_wait(output logic [31:0] res, output int lat);
    bus_write(4'd9, 8'h00);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(lat);
    read32(4'd9, res);
  endtask

  task automatic ack();
    @(negedge clk);
    end_ack = 1'b1;
    @(negedge clk);
    end_ack = 1'b0;
    check("cmd_end_after_ack", {31'd0, cmd_end}, 32'd0);
  endtask

  // Reference model: exact real arithmetic, then truncation to binary32.
  function automatic real f2r(input logic [31:0] x);
    real m;
    if (x[30:23] == 8'd0) return 0.0;
    m = (1.0 + real'(x[22:0]) / 8388608.0) * $pow(2.0, real'(int'(x[30:23]) - 127));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r, input logic zsign);
    real m;
    int  e, be;
    logic s;
    if (r == 0.0) return {zsign, 31'd0};
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    be = e + 127;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be <= 0)   return {s, 31'd0};
    return {s, 8'(be), 23'(int'($floor((m - 1.0) * 8388608.0)))};
  endfunction

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    real ra, rb, r;
    logic zs;
    ra = f2r(a);
    rb = f2r(b);
    case (op)
      2'd0: begin r = ra + rb; zs = a[31] & b[31];  end
      2'd1: begin r = ra - rb; zs = a[31] & ~b[31]; end
      2'd2: begin r = ra * rb; zs = a[31] ^ b[31];  end
      default: begin r = ra / rb; zs = a[31] ^ b[31]; end
    endcase
    return r2f(r, zs);
  endfunction

  initial begin
    logic [31:0] res, a, b;
    logic [7:0]  byt;
    logic [1:0]  op;
    int          lat;

    vt[0]  = '{32'h3F800000, 32'h3F8CCCCD, 2'd0, 32'h40066666, 8};
    vt[1]  = '{32'h40000000, 32'h41200000, 2'd2, 32'h41A00000, 8};
    vt[2]  = '{32'h40000000, 32'h41200000, 2'd3, 32'h3E4CCCCC, 32};
    vt[3]  = '{32'h40000000, 32'h41200000, 2'd1, 32'hC1000000, 8};
    vt[4]  = '{32'h3FFFFFFF, 32'h40490FDA, 2'd3, 32'h3F22F983, 32};
    vt[5]  = '{32'h4CBEBC20, 32'h00000000, 2'd0, 32'h4CBEBC20, 8};
    vt[6]  = '{32'h3F800000, 32'h00000000, 2'd3, 32'h7F800000, 32};
    vt[7]  = '{32'h00000000, 32'h00000000, 2'd3, 32'h7FC00000, 32};
    vt[8]  = '{32'h3F800000, 32'h3F800000, 2'd1, 32'h00000000, 8};
    vt[9]  = '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 8};
    vt[10] = '{32'h7F800000, 32'h7F800000, 2'd1, 32'h7FC00000, 8};
    vt[11] = '{32'h00000000, 32'hFF800000, 2'd2, 32'h7FC00000, 8};
    vt[12] = '{32'h7F800000, 32'hC0000000, 2'd2, 32'hFF800000, 8};
    vt[13] = '{32'h3F800000, 32'hFF800000, 2'd3, 32'h80000000, 32};
    vt[14] = '{32'h7F000000, 32'h7F000000, 2'd2, 32'h7F800000, 8};
    vt[15] = '{32'h80800000, 32'h00800000, 2'd2, 32'h80000000, 8};
    vt[16] = '{32'h80000000, 32'h80000000, 2'd0, 32'h80000000, 8};
    vt[17] = '{32'h00400000, 32'h7E800000, 2'd2, 32'h00000000, 8};
    vt[18] = '{32'h3F800000, 32'h33000000, 2'd1, 32'h3F7FFFFF, 8};
    vt[19] = '{32'h3F800000, 32'h26800000, 2'd1, 32'h3F7FFFFF, 8};

    repeat (3) @(negedge clk);
    arst = 1'b1;
    for (int i = 9; i <= 13; i++) begin
      bus_read(4'(i), byt);
      check($sformatf("reset_read_%0d", i), {24'd0, byt}, 32'd0);
    end
    check("reset_cmd_end", {31'd0, cmd_end}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    foreach (vt[i]) begin
      load(vt[i].a, vt[i].b, vt[i].op);
      start_and_wait(res, lat);
      check($sformatf("vec%0d_result", i), res, vt[i].exp);
      check($sformatf("vec%0d_latency_ok", i), {31'd0, (lat <= vt[i].maxlat)}, 32'd1);
      ack();
    end

    for (int n = 0; n < 40; n++) begin
      a  = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 140)), 23'($urandom)};
      b  = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 140)), 23'($urandom)};
      op = 2'($urandom_range(0, 3));
      load(a, b, op);
      start_and_wait(res, lat);
      check($sformatf("rand%0d_op%0d_%08h_%08h", n, op, a, b), res, ref_op(a, b, op));
      check($sformatf("rand%0d_latency_ok", n), {31'd0, (lat <= (op == 2'd3 ? 32 : 8))}, 32'd1);
      ack();
    end

    // Writes and a second start during a running divide.
    load(32'h40000000, 32'h41200000, 2'd3);
    bus_write(4'd9, 8'h00);
    for (int i = 0; i < 4; i++) bus_write(4'(i), 8'(32'h40400000 >> (8 * i)));
    bus_write(4'd9, 8'h00);
    check("busy_holds_second_start", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("busy_seq_done_seen", {31'd0, cmd_end}, 32'd1);
    read32(4'd9, res);
    check("busy_seq_first_result", res, 32'h3E4CCCCC);
    repeat (3) @(negedge clk);
    check("cmd_end_level_held", {31'd0, cmd_end}, 32'd1);
    read32(4'd0, res);
    check("operand_a_written_in_busy", res, 32'h40400000);
    ack();
    start_and_wait(res, lat);
    check("next_op_uses_new_a", res, 32'h3E999999);
    ack();

    // end_ack already high at completion gives a one-cycle cmd_end.
    end_ack = 1'b1;
    load(32'h3F800000, 32'h3F800000, 2'd0);
    bus_write(4'd9, 8'h00);
    wait_done(lat);
    check("pulse_cmd_end_seen", {31'd0, cmd_end}, 32'd1);
    @(negedge clk);
    check("pulse_cmd_end_cleared", {31'd0, cmd_end}, 32'd0);
    end_ack = 1'b0;
    read32(4'd9, res);
    check("pulse_result", res, 32'h40000000);

    // Reset during a divide aborts it and clears the registers.
    load(32'h40000000, 32'h41200000, 2'd3);
    bus_write(4'd9, 8'h00);
    repeat (5) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_cmd_end", {31'd0, cmd_end}, 32'd0);
    read32(4'd9, res);
    check("midreset_result", res, 32'h00000000);
    read32(4'd0, res);
    check("midreset_operand_a", res, 32'h00000000);
    repeat (35) @(negedge clk);
    check("midreset_no_late_done", {31'd0, cmd_end}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
